// File: rtl/alu_mdu_exec.sv
// RV32I ALU plus iterative RV32M multiply/divide execute unit behind valid/ready handshakes.
// Single-cycle ops answer one cycle after transfer; MUL*/DIV*/REM* take one bit per cycle.
module alu_mdu_exec #(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            op5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t             state, state_nxt;
    logic [XLEN-1:0]    opa_q, opb_q;
    logic [2*XLEN-1:0]  acc, acc_nxt, prod;
    logic [SHAMT_W-1:0] cnt, shamt;
    logic               neg_q, hi_q, rem_q;

    logic                   fire, is_m, div_zero, div_ovf, iter_op, done;
    logic                   a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]        alu_res, single_res, iter_res, done_res, mag_a, mag_b, div_val;
    logic signed [XLEN-1:0] sra_res;
    logic [XLEN:0]          rem_try, rem_diff;

    assign shamt   = src_b[SHAMT_W-1:0];
    assign sra_res = $signed(src_a) >>> shamt;
    assign fire    = in_valid && in_ready;

    // NOTE: every always_comb assigns defaults first, so no path can infer a latch.
    always_comb begin
        alu_res = src_a + src_b;
        if (alu_op == 2'b01) begin
            alu_res = src_a - src_b;
        end else if (alu_op == 2'b10) begin
            case (funct3)
                3'b000:  alu_res = (op5 && funct7[5]) ? src_a - src_b : src_a + src_b;
                3'b001:  alu_res = src_a << shamt;
                3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
                3'b011:  alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
                3'b100:  alu_res = src_a ^ src_b;
                3'b101:  alu_res = funct7[5] ? sra_res : src_a >> shamt;
                3'b110:  alu_res = src_a | src_b;
                default: alu_res = src_a & src_b;
            endcase
        end
    end

    // M-group decode; divide-by-zero and signed overflow resolve without iterating.
    always_comb begin
        is_m       = (alu_op == 2'b10) && op5 && (funct7 == 7'b0000001);
        div_zero   = funct3[2] && (src_b == '0);
        div_ovf    = funct3[2] && !funct3[0] && (src_a == MIN_NEG) && (src_b == '1);
        iter_op    = is_m && !div_zero && !div_ovf;
        a_sgn      = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
        b_sgn      = funct3[2] ? !funct3[0] : !funct3[1];
        a_neg      = a_sgn && src_a[XLEN-1];
        b_neg      = b_sgn && src_b[XLEN-1];
        mag_a      = a_neg ? -src_a : src_a;
        mag_b      = b_neg ? -src_b : src_b;
        single_res = alu_res;
        if (is_m && div_zero) begin
            single_res = funct3[1] ? src_a : '1;
        end else if (is_m && div_ovf) begin
            single_res = funct3[1] ? '0 : src_a;
        end
    end

    // One shift-add (MSB-first) or one restoring-division step per cycle.
    always_comb begin
        rem_try  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        rem_diff = rem_try - {1'b0, opb_q};
        acc_nxt  = acc;
        if (state == MUL_RUN) begin
            acc_nxt = {acc[2*XLEN-2:0], 1'b0} + (opb_q[cnt] ? {{XLEN{1'b0}}, opa_q} : '0);
        end else if (state == DIV_RUN) begin
            if (rem_try >= {1'b0, opb_q}) begin
                acc_nxt = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_try[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end
        prod    = neg_q ? -acc_nxt : acc_nxt;
        div_val = rem_q ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
        if (state == MUL_RUN) begin
            iter_res = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end else begin
            iter_res = neg_q ? -div_val : div_val;
        end
        done     = (fire && !iter_op) || ((state != IDLE) && (cnt == '0));
        done_res = (state == IDLE) ? single_res : iter_res;
    end

    // NOTE: registers take non-blocking assignments so each samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fire && iter_op) begin
                    if (funct3[2]) state_nxt = DIV_RUN;
                    else           state_nxt = MUL_RUN;
                end
            end
            default: begin
                if (cnt == '0) state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        in_ready = (state == IDLE) && (!out_valid || out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            cnt       <= '0;
            acc       <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            hi_q      <= 1'b0;
            rem_q     <= 1'b0;
        end else begin
            if (done) begin
                out_valid <= 1'b1;
                result    <= done_res;
                zero      <= (done_res == '0);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (fire && iter_op) begin
                opa_q <= mag_a;
                opb_q <= mag_b;
                neg_q <= (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                hi_q  <= (funct3[1:0] != 2'b00);
                rem_q <= funct3[1];
                acc   <= funct3[2] ? {{XLEN{1'b0}}, mag_a} : '0;
                cnt   <= SHAMT_W'(XLEN - 1);
            end else if (state != IDLE) begin
                acc <= acc_nxt;
                if (cnt != '0) cnt <= cnt - SHAMT_W'(1);
            end
        end
    end
endmodule
